// File: rtl/lpt_pkg.sv
// Shared types and default constants for the LPT peripheral-side receiver.
package lpt_pkg;

  // Receiver handshake states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_REL   = 2'd1,
    WAIT_SPACE = 2'd2,
    ACK        = 2'd3
  } lpt_rx_state_t;

  localparam int unsigned LPT_ACK_CYCLES_DEF = 32'd250;
  localparam int unsigned LPT_FIFO_DEPTH_DEF = 32'd16;

  typedef logic [7:0] lpt_byte_t;

endpackage

// File: rtl/lpt_rx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rd_data
// whenever valid is high. Pops on an empty FIFO and pushes on a full FIFO
// are ignored. flush empties the FIFO in one cycle.
module lpt_rx_fifo
  import lpt_pkg::*;
#(
  parameter int unsigned DEPTH = LPT_FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [AW:0]      level_next_s;
  logic             full_r;
  logic             valid_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & valid_r;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    level_next_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level_r + (AW+1)'(1);
      2'b01:   level_next_s = level_r - (AW+1)'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, occupancy and registered status flags
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      full_r  <= (level_next_s == (AW+1)'(DEPTH));
      valid_r <= (level_next_s != '0);
    end
  end

  // Storage array; data needs no reset since valid gates it
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign valid   = valid_r;
  assign empty   = ~valid_r;
  assign full    = full_r;
  assign level   = level_r;

endmodule

// File: rtl/lpt_peripheral_rx.sv
// Centronics peripheral-side receiver: synchronises the host STROBE/INIT
// pins, runs the STROBE/BUSY/ACK handshake and queues received bytes in a
// show-ahead FIFO drained over a valid/ready port.
// Optional build macro: LPT_STROBE_FILTER_EN adds a FILTER_CYCLES-long
// glitch filter on the synchronised strobe.
module lpt_peripheral_rx
  import lpt_pkg::*;
#(
  parameter int unsigned CLK_MHZ       = 32'd50,
  parameter int unsigned ACK_CYCLES    = LPT_ACK_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH    = LPT_FIFO_DEPTH_DEF,
  parameter int unsigned FILTER_CYCLES = 32'd4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lpt_strobe_n,
  input  logic [7:0]                    lpt_data,
  input  logic                          lpt_init_n,
  output logic                          lpt_ack_n,
  output logic                          lpt_busy,
  output logic                          lpt_sel,
  output logic                          lpt_pout,
  input  logic                          paper_out,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          protocol_err,
  input  logic                          err_clr
);

  localparam int unsigned ACW = (ACK_CYCLES > 32'd1) ? $clog2(ACK_CYCLES) : 32'd1;

  // CLK_MHZ is informational only; FILTER_CYCLES matters only with the filter
  if ((CLK_MHZ == 32'd0) || (FILTER_CYCLES == 32'd0)) begin : g_cfg_info
  end

  logic            strobe_meta_r;
  logic            strobe_sync_r;
  logic            init_meta_r;
  logic            init_sync_r;
  logic            strobe_prev_r;
  logic            strobe_level_s;
  logic            fall_s;
  logic            init_active_s;

  lpt_rx_state_t   state_r;
  lpt_rx_state_t   state_next_s;
  logic [ACW-1:0]  ack_cnt_r;
  logic [ACW-1:0]  ack_cnt_next_s;
  lpt_byte_t       capture_r;
  logic            capture_load_s;
  logic            push_s;
  logic            err_set_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  // Two-stage synchronisers for the asynchronous host control pins
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_meta_r <= 1'b1;
      strobe_sync_r <= 1'b1;
      init_meta_r   <= 1'b1;
      init_sync_r   <= 1'b1;
    end else begin
      strobe_meta_r <= lpt_strobe_n;
      strobe_sync_r <= strobe_meta_r;
      init_meta_r   <= lpt_init_n;
      init_sync_r   <= init_meta_r;
    end
  end

`ifdef LPT_STROBE_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_CYCLES + 32'd1);

  logic           filt_level_r;
  logic [FCW-1:0] filt_cnt_r;

  // Level follows the strobe only after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_level_r <= 1'b1;
      filt_cnt_r   <= '0;
    end else if (strobe_sync_r == filt_level_r) begin
      filt_cnt_r   <= '0;
    end else if (filt_cnt_r == FCW'(FILTER_CYCLES - 32'd1)) begin
      filt_level_r <= strobe_sync_r;
      filt_cnt_r   <= '0;
    end else begin
      filt_cnt_r   <= filt_cnt_r + FCW'(1);
    end
  end

  assign strobe_level_s = filt_level_r;
`else
  assign strobe_level_s = strobe_sync_r;
`endif

  // Previous strobe level for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_prev_r <= 1'b1;
    end else begin
      strobe_prev_r <= strobe_level_s;
    end
  end

  assign fall_s        = strobe_prev_r & ~strobe_level_s;
  assign init_active_s = ~init_sync_r;

  // Handshake next-state, capture/push strobes and protocol-error detection
  always_comb begin
    state_next_s   = state_r;
    ack_cnt_next_s = ack_cnt_r;
    capture_load_s = 1'b0;
    push_s         = 1'b0;
    err_set_s      = 1'b0;
    if (init_active_s) begin
      state_next_s   = IDLE;
      ack_cnt_next_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            capture_load_s = 1'b1;
            state_next_s   = WAIT_REL;
          end else begin
            state_next_s   = IDLE;
          end
        end
        WAIT_REL: begin
          if (strobe_level_s) begin
            state_next_s = WAIT_SPACE;
          end else begin
            state_next_s = WAIT_REL;
          end
        end
        WAIT_SPACE: begin
          if (!fifo_full_s) begin
            push_s         = 1'b1;
            ack_cnt_next_s = ACW'(ACK_CYCLES - 32'd1);
            state_next_s   = ACK;
          end else begin
            state_next_s   = WAIT_SPACE;
          end
        end
        ACK: begin
          if (ack_cnt_r == '0) begin
            state_next_s   = IDLE;
          end else begin
            ack_cnt_next_s = ack_cnt_r - ACW'(1);
          end
        end
        default: begin
          state_next_s   = IDLE;
          ack_cnt_next_s = '0;
        end
      endcase
      // A host strobe outside IDLE is a violation; the byte is dropped
      if (fall_s && (state_r != IDLE)) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = 1'b0;
      end
    end
  end

  // State, ACK counter and capture register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ack_cnt_r <= '0;
      capture_r <= 8'h00;
    end else begin
      state_r   <= state_next_s;
      ack_cnt_r <= ack_cnt_next_s;
      if (capture_load_s) begin
        capture_r <= lpt_data;
      end
    end
  end

  // Host-facing outputs derived from the next state so they track it without lag
  always_ff @(posedge clk) begin
    if (reset) begin
      lpt_ack_n    <= 1'b1;
      lpt_busy     <= 1'b0;
      lpt_sel      <= 1'b1;
      lpt_pout     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      lpt_ack_n <= (state_next_s != ACK);
      lpt_busy  <= init_active_s | (state_next_s != IDLE);
      lpt_sel   <= ~init_active_s;
      lpt_pout  <= paper_out;
      if (err_set_s) begin
        protocol_err <= 1'b1;
      end else if (err_clr || init_active_s) begin
        protocol_err <= 1'b0;
      end
    end
  end

  lpt_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32'd8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (init_active_s),
    .push      (push_s),
    .push_data (capture_r),
    .pop       (rd_ready),
    .rd_data   (rd_data),
    .valid     (rd_valid),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_lpt_peripheral_rx.sv
// Directed self-checking bench for lpt_peripheral_rx (default parameters).
module tb_lpt_peripheral_rx;

`ifdef LPT_STROBE_FILTER_EN
  localparam int FEXTRA = 4;
`else
  localparam int FEXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       lpt_strobe_n;
  logic [7:0] lpt_data;
  logic       lpt_init_n;
  logic       lpt_ack_n;
  logic       lpt_busy;
  logic       lpt_sel;
  logic       lpt_pout;
  logic       paper_out;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] fifo_level;
  logic       protocol_err;
  logic       err_clr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lpt_peripheral_rx dut (
    .clk          (clk),
    .reset        (reset),
    .lpt_strobe_n (lpt_strobe_n),
    .lpt_data     (lpt_data),
    .lpt_init_n   (lpt_init_n),
    .lpt_ack_n    (lpt_ack_n),
    .lpt_busy     (lpt_busy),
    .lpt_sel      (lpt_sel),
    .lpt_pout     (lpt_pout),
    .paper_out    (paper_out),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .fifo_level   (fifo_level),
    .protocol_err (protocol_err),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_pulse(input logic [7:0] d, input int low);
    lpt_data = d;
    tick(1);
    lpt_strobe_n = 1'b0;
    tick(low);
    lpt_strobe_n = 1'b1;
  endtask

  task automatic wait_ack(input logic lvl, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (lpt_ack_n === lvl) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    bit seen;
    strobe_pulse(d, 6);
    wait_ack(1'b0, 60, seen);
    check({tag, " ack_start"}, 32'(seen), 32'd1);
    wait_ack(1'b1, 300, seen);
    check({tag, " ack_end"}, 32'(seen), 32'd1);
  endtask

  task automatic pop_one(input logic [7:0] exp, input string tag);
    check({tag, " valid"}, 32'(rd_valid), 32'd1);
    check({tag, " data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    bit busy_ok;
    int lat;
    int cnt;

    reset        = 1'b1;
    lpt_strobe_n = 1'b1;
    lpt_init_n   = 1'b1;
    lpt_data     = 8'h00;
    paper_out    = 1'b0;
    rd_ready     = 1'b0;
    err_clr      = 1'b0;
    tick(3);
    check("rst ack_n", 32'(lpt_ack_n), 32'd1);
    check("rst busy", 32'(lpt_busy), 32'd0);
    check("rst sel", 32'(lpt_sel), 32'd1);
    check("rst pout", 32'(lpt_pout), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst level", 32'(fifo_level), 32'd0);
    check("rst err", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    tick(2);

    // paper_out forwarding with one cycle of delay
    paper_out = 1'b1;
    tick(1);
    check("pout high", 32'(lpt_pout), 32'd1);
    paper_out = 1'b0;
    tick(1);
    check("pout low", 32'(lpt_pout), 32'd0);

    // Single byte 0xA5 with full ACK timing
    lpt_data = 8'hA5;
    tick(1);
    lpt_strobe_n = 1'b0;
    lat = 0;
    while ((lpt_busy !== 1'b1) && (lat < 20)) begin
      tick(1);
      lat++;
    end
    check("single busy latency ok", 32'(lat <= 4 + FEXTRA), 32'd1);
    tick(25 - lat);
    lpt_strobe_n = 1'b1;
    wait_ack(1'b0, 60, seen);
    check("single ack_start", 32'(seen), 32'd1);
    cnt = 0;
    busy_ok = 1'b1;
    while ((lpt_ack_n === 1'b0) && (cnt < 400)) begin
      if (lpt_busy !== 1'b1) busy_ok = 1'b0;
      tick(1);
      cnt++;
    end
    check("single ack width", 32'(cnt), 32'd250);
    check("single busy during ack", 32'(busy_ok), 32'd1);
    check("single ack_n after", 32'(lpt_ack_n), 32'd1);
    check("single busy drops with ack", 32'(lpt_busy), 32'd0);
    check("single level", 32'(fifo_level), 32'd1);
    pop_one(8'hA5, "single pop");
    check("single empty level", 32'(fifo_level), 32'd0);
    check("single empty valid", 32'(rd_valid), 32'd0);

    // Fill to 16 then back-pressure the 17th byte
    for (int i = 0; i < 16; i++) begin
      send(8'(i), "fill");
    end
    check("fill level 16", 32'(fifo_level), 32'd16);
    strobe_pulse(8'h10, 6);
    tick(40);
    check("full busy held", 32'(lpt_busy), 32'd1);
    check("full no ack", 32'(lpt_ack_n), 32'd1);
    check("full level", 32'(fifo_level), 32'd16);
    pop_one(8'h00, "full pop0");
    wait_ack(1'b0, 10, seen);
    check("full 17th ack_start", 32'(seen), 32'd1);
    wait_ack(1'b1, 300, seen);
    check("full 17th ack_end", 32'(seen), 32'd1);
    check("full level again", 32'(fifo_level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      pop_one(8'(i), "drain");
    end
    check("drain level 0", 32'(fifo_level), 32'd0);

    // Second strobe during ACK is a protocol violation
    strobe_pulse(8'h3C, 6);
    wait_ack(1'b0, 60, seen);
    check("perr ack_start", 32'(seen), 32'd1);
    tick(10);
    check("perr not yet", 32'(protocol_err), 32'd0);
    strobe_pulse(8'h77, 6);
    tick(8);
    check("perr set", 32'(protocol_err), 32'd1);
    wait_ack(1'b1, 300, seen);
    check("perr ack_end", 32'(seen), 32'd1);
    tick(5);
    check("perr level 1", 32'(fifo_level), 32'd1);
    check("perr busy idle", 32'(lpt_busy), 32'd0);
    check("perr sticky", 32'(protocol_err), 32'd1);
    pop_one(8'h3C, "perr pop");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("perr cleared", 32'(protocol_err), 32'd0);
    check("perr level 0", 32'(fifo_level), 32'd0);

    // INIT asserted mid-ACK with three bytes queued
    send(8'h11, "init q1");
    send(8'h22, "init q2");
    strobe_pulse(8'h33, 6);
    wait_ack(1'b0, 60, seen);
    check("init q3 ack_start", 32'(seen), 32'd1);
    check("init level 3", 32'(fifo_level), 32'd3);
    lpt_init_n = 1'b0;
    tick(4);
    check("init ack_n", 32'(lpt_ack_n), 32'd1);
    check("init busy", 32'(lpt_busy), 32'd1);
    check("init sel", 32'(lpt_sel), 32'd0);
    check("init level flushed", 32'(fifo_level), 32'd0);
    check("init rd_valid", 32'(rd_valid), 32'd0);
    tick(6);
    check("init busy hold", 32'(lpt_busy), 32'd1);
    check("init sel hold", 32'(lpt_sel), 32'd0);
    lpt_init_n = 1'b1;
    tick(5);
    check("post init busy", 32'(lpt_busy), 32'd0);
    check("post init sel", 32'(lpt_sel), 32'd1);
    check("post init ack_n", 32'(lpt_ack_n), 32'd1);
    check("post init level", 32'(fifo_level), 32'd0);

    // Push and pop in the same cycle at level 5
    for (int i = 0; i < 5; i++) begin
      send(8'h50 + 8'(i), "pp fill");
    end
    check("pp level 5", 32'(fifo_level), 32'd5);
    lpt_data = 8'h55;
    tick(1);
    lpt_strobe_n = 1'b0;
    tick(6);
    lpt_strobe_n = 1'b1;
    // Strobe release: 2 sync stages, WAIT_REL exit, one WAIT_SPACE cycle, then push
    tick(3 + FEXTRA);
    check("pp pre level", 32'(fifo_level), 32'd5);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("pp push happened", 32'(lpt_ack_n), 32'd0);
    check("pp level held", 32'(fifo_level), 32'd5);
    wait_ack(1'b1, 300, seen);
    check("pp ack_end", 32'(seen), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      pop_one(8'h50 + 8'(i), "pp drain");
    end
    check("pp level 0", 32'(fifo_level), 32'd0);

`ifdef LPT_STROBE_FILTER_EN
    // Short glitch is filtered, a 6-cycle pulse is accepted
    tick(5);
    lpt_strobe_n = 1'b0;
    tick(2);
    lpt_strobe_n = 1'b1;
    tick(15);
    check("filt glitch busy", 32'(lpt_busy), 32'd0);
    check("filt glitch err", 32'(protocol_err), 32'd0);
    check("filt glitch level", 32'(fifo_level), 32'd0);
    send(8'h9E, "filt pulse");
    check("filt level 1", 32'(fifo_level), 32'd1);
    pop_one(8'h9E, "filt pop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
